fifo_rd_pop_ctrl: RTL
=====================

// Module: fifo_rd_pop_ctrl
// PURPOSE
//   Read-domain consumer of the async FIFO read-pointer stage. Watches rempty, issues rinc,
//   captures the word read at raddr, and presents it to downstream logic (e.g. UART TX) over
//   a valid/ready interface through a 2-entry output buffer.
//   rempty is derived from a registered gray pointer that lags one cycle behind each pop,
//   so this block enforces a one-cycle guard after every pop.
// PARAMETERS
//   DATA_WIDTH  8   width of FIFO words and of out_data
//   CNT_WIDTH   16  width of pop_count (used only with FIFO_POP_CNT_EN)
// PORTS
//   clk          in   1           read-domain clock (same clock as the FIFO read side)
//   rst          in   1           synchronous, active-high reset
//   fifo_rdata   in   DATA_WIDTH  FIFO memory read data at current raddr (combinational read)
//   fifo_rempty  in   1           FIFO empty flag from read-pointer stage
//   fifo_rinc    out  1           pop request to read-pointer stage
//   out_data     out  DATA_WIDTH  head word of output buffer
//   out_valid    out  1           out_data holds a valid word
//   out_ready    in   1           downstream accepts word when out_valid && out_ready
//   pop_count    out  CNT_WIDTH   accepted-transfer counter (FIFO_POP_CNT_EN only)
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//     - Buffer count <= 0; guard <= 0.
//     - out_valid=0, out_data=0, pop_count=0.
//     - fifo_rinc forced 0 while rst=1.
//     - Buffered words are discarded. FIFO pointers are not touched.
//   - Buffer: 2 registers, head/tail, count in {0,1,2}. States EMPTY(0), ONE(1), FULL(2).
//   - fifo_rinc (combinational) = !rst && !fifo_rempty && !guard && (count<2 || accept).
//     - accept = out_valid && out_ready.
//   - Pop edge: when fifo_rinc=1, fifo_rdata is written to the tail slot on that posedge.
//     - The word appears on out_data (if it becomes head) the next cycle.
//     - Latency rempty-fall -> out_valid is 1 cycle.
//   - guard <= fifo_rinc each cycle, so there are no back-to-back pops.
//     - Maximum throughput is 1 word per 2 cycles.
//   - out_valid = (count != 0), registered. out_data = head slot.
//     - out_data must stay stable while out_valid && !out_ready.
//   - Transitions:
//     - EMPTY: pop -> ONE.
//     - ONE: pop && !accept -> FULL; accept && !pop -> EMPTY; both -> ONE, new word becomes head.
//     - FULL: accept && !pop -> ONE; accept && pop -> FULL, order preserved.
//     - FULL: no pop without accept.
//   - Word order out == order popped; no word is dropped or duplicated.
//   - out_ready high while out_valid=0 has no effect.
//   - fifo_rempty toggling during the guard cycle is ignored until the guard clears.
// CONFIGURATION
//   FIFO_POP_CNT_EN defined:
//     - pop_count port exists; increments by 1 on every accept.
//     - Wraps 2^CNT_WIDTH-1 -> 0; cleared by rst.
//   FIFO_POP_CNT_EN undefined:
//     - pop_count port and counter logic are absent; all other behaviour is identical.
// TESTING
//   1 Reset: rst=1 for 2 cycles, fifo_rempty=0 -> fifo_rinc=0 throughout; out_valid=0, pop_count=0.
//   2 Single word: fifo_rempty 1->0, fifo_rdata=0xA5, out_ready=0 -> fifo_rinc=1 for one cycle;
//     next cycle out_valid=1, out_data=0xA5; fifo_rinc=0 in the guard cycle.
//   3 Backpressure: fifo_rempty=0 with data 0x01,0x02,0x03, out_ready=0 -> exactly 2 pops,
//     then fifo_rinc stays 0; release out_ready -> outputs 0x01,0x02,0x03 in order.
//   4 Streaming: out_ready=1, 8 words 0x10..0x17 -> pops every 2nd cycle;
//     out sequence 0x10..0x17 with no loss or duplicates.
//   5 Mid-op reset: FULL state, assert rst 1 cycle -> next cycle out_valid=0,
//     fifo_rinc=0 during rst, old words never appear.
//   6 Counter (FIFO_POP_CNT_EN, CNT_WIDTH=4): 17 accepted transfers -> pop_count=1 (wrap).

Source files
------------

// File: rtl/fifo_rd_pop_ctrl.sv
// Read-side pop controller: drains an async FIFO into a 2-entry valid/ready output buffer.
// Optional accepted-transfer counter enabled by defining FIFO_POP_CNT_EN.
module fifo_rd_pop_ctrl #(
    parameter int unsigned DATA_WIDTH = 8
`ifdef FIFO_POP_CNT_EN
   ,parameter int unsigned CNT_WIDTH  = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_rempty,
    output logic                  fifo_rinc,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef FIFO_POP_CNT_EN
   ,output logic [CNT_WIDTH-1:0]  pop_count
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic                  valid_q;
    logic                  guard_q;
    logic                  accept;

    assign accept    = valid_q && out_ready;
    assign out_valid = valid_q;
    assign out_data  = head_q;

    // rempty lags each pop by a cycle, so guard_q blocks the very next pop.
    always_comb begin
        fifo_rinc = !rst && !fifo_rempty && !guard_q && ((state_q != FULL) || accept);
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (fifo_rinc) begin
                    head_d  = fifo_rdata;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (fifo_rinc && accept) begin
                    head_d = fifo_rdata;
                end else if (fifo_rinc) begin
                    tail_d  = fifo_rdata;
                    state_d = FULL;
                end else if (accept) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (accept) begin
                    head_d  = tail_q;
                    state_d = ONE;
                    if (fifo_rinc) begin
                        tail_d  = fifo_rdata;
                        state_d = FULL;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
            guard_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= (state_d != EMPTY);
            guard_q <= fifo_rinc;
        end
    end

`ifdef FIFO_POP_CNT_EN
    logic [CNT_WIDTH-1:0] pop_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_count_q <= '0;
        end else if (accept) begin
            pop_count_q <= pop_count_q + 1'b1;
        end
    end

    assign pop_count = pop_count_q;
`endif

endmodule
